uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
UART transmit path for the APB-UART bridge. It accepts one parallel word from the TX FIFO/APB side through a valid/ready handshake and serializes it onto tx_serial as a frame: start bit, data LSB-first, optional parity, stop bit(s). Bit timing is derived from an external oversample tick shared with the receive path. It is the transmit counterpart of the RX deserializer and uses the same frame format and oversample rate.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9)
OVERSAMPLE, 16, baud_tick pulses per bit period (>=2)
PARITY_EN, 1, 1 = insert parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
UCLK  input  1  UART clock
reset  input  1  asynchronous active-low reset
baud_tick  input  1  one-UCLK pulse at OVERSAMPLE x baud rate
tx_data  input  DATA_WIDTH  word to send, sampled at handshake
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a word
tx_serial  output  1  serial line, idle high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse: frame fully sent

Behaviour:
- Clocking: one clock, UCLK; reset is asynchronous and active-low (port reset). All state is in UCLK; reset asserts immediately, regardless of clock.
- Reset values: tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, counters=0.
- Handshake: a transfer occurs on a UCLK edge with tx_valid&&tx_ready. tx_data is latched into a shift register. Parity (^tx_data XOR PARITY_ODD) is latched at the same edge. tx_valid without tx_ready is ignored; the word is not queued.
- FSM states: IDLE -> START -> DATA -> PARITY (skipped if PARITY_EN=0) -> STOP -> IDLE.
- IDLE: tx_serial=1, tx_ready=1, tx_busy=0. On handshake, go to START. The next cycle, tx_ready=0, tx_busy=1, tx_serial=0.
- Bit timing: a tick counter (width clog2(OVERSAMPLE)) clears on entry to each bit. Each bit ends on the baud_tick that brings the count to OVERSAMPLE, and the state/bit change is visible the following cycle. With baud_tick tied high, every bit is exactly OVERSAMPLE UCLK cycles.
- DATA: tx_serial = shift_reg[0]. The register shifts right at each bit end. A bit index 0..DATA_WIDTH-1 selects the exit after the last bit.
- PARITY: tx_serial = latched parity bit, for one bit period.
- STOP: tx_serial=1 for STOP_BITS bit periods. At the end of the final stop period, the block goes to IDLE, pulses tx_done=1 for exactly one cycle, and raises tx_ready in that same cycle.
- Back-to-back: a handshake in the tx_done cycle is legal. The next start bit then begins the following cycle, with no extra idle cycles between frames.
- baud_tick gaps: the counter holds and tx_serial is stable when no tick arrives. baud_tick during IDLE has no effect.
- tx_data changes after the handshake do not affect the frame in flight.
- Reset mid-frame: the line returns to 1 immediately and the frame is aborted. No tx_done is produced.
- tx_serial is a registered output, with no combinational path from inputs.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP), also used by the RX FSM;
  - constants UART_IDLE_LEVEL=1'b1, UART_START_LEVEL=1'b0;
  - the parity-mode encoding.
- No sub-module is required. Parity is a reduction, and the bit timer is an inline counter.
- The oversample tick generator uart_baud_gen is a separate shared block instantiated at the top level, not inside this one.

Test Plan:
- Defaults, baud_tick=1, send 0xA5 -> tx_serial shows 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1, each bit 16 cycles. tx_done pulses 176 cycles after the first start-bit cycle; tx_ready is low throughout.
- PARITY_ODD=1, send 0x00 -> parity bit 1. PARITY_EN=0, send 0xFF -> 10-bit frame (160 cycles), no parity slot.
- Back-to-back: hold tx_valid with 0x3C then 0xC3 -> second handshake lands on the tx_done cycle. The second start bit follows immediately, with zero idle cycles between frames.
- tx_valid pulsed with 0x55 mid-frame while tx_ready=0 -> ignored: no corruption of the current frame, and no extra frame afterwards.
- baud_tick every 4th cycle, OVERSAMPLE=16 -> each bit lasts 64 cycles, and the line is stable between ticks. STOP_BITS=2 -> stop high for 2 bit periods before tx_done.
- Assert reset during DATA bit 3 -> tx_serial=1, tx_ready=1, tx_busy=0 asynchronously, and no tx_done. A new 0x81 sent after release -> full correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, line levels and parity mode.
// Used by both the transmit serializer and the receive deserializer.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } uart_parity_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity,
// stop bit(s), timed by an external oversample tick.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  UCLK,
    input  logic                  reset,
    input  logic                  baud_tick,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_serial,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    localparam uart_parity_e PAR_MODE = PARITY_ODD ? PAR_ODD : PAR_EVEN;

    uart_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  serial_q, serial_d;
    logic                  done_q, done_d;
    logic                  bit_end;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        done_d   = 1'b0;
        serial_d = UART_IDLE_LEVEL;
        bit_end  = 1'b0;

        if (state_q != IDLE && baud_tick) begin
            bit_end = (cnt_q == CNT_LAST);
            cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (tx_valid) begin
                    state_d = START;
                    shift_d = tx_data;
                    par_d   = (^tx_data) ^ logic'(PAR_MODE);
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the next state so tx_serial stays a flop output
        unique case (state_d)
            START:   serial_d = UART_START_LEVEL;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = par_d;
            default: serial_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            serial_q <= UART_IDLE_LEVEL;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    assign tx_ready  = (state_q == IDLE);
    assign tx_busy   = (state_q != IDLE);
    assign tx_serial = serial_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: three parameterisations share
// clock, reset and baud_tick; each frame is checked bit by bit.
module tb_uart_tx_serializer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic baud_tick = 1'b0;

    logic       valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
    logic [7:0] data_a = '0, data_b = '0, data_c = '0;
    logic       rdy_a, rdy_b, rdy_c;
    logic       ser_a, ser_b, ser_c;
    logic       bsy_a, bsy_b, bsy_c;
    logic       dne_a, dne_b, dne_c;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    uart_tx_serializer u_a (
        .UCLK(clk), .reset(reset), .baud_tick(baud_tick),
        .tx_data(data_a), .tx_valid(valid_a), .tx_ready(rdy_a),
        .tx_serial(ser_a), .tx_busy(bsy_a), .tx_done(dne_a)
    );

    uart_tx_serializer #(.PARITY_ODD(1'b1), .STOP_BITS(2)) u_b (
        .UCLK(clk), .reset(reset), .baud_tick(baud_tick),
        .tx_data(data_b), .tx_valid(valid_b), .tx_ready(rdy_b),
        .tx_serial(ser_b), .tx_busy(bsy_b), .tx_done(dne_b)
    );

    uart_tx_serializer #(.PARITY_EN(1'b0)) u_c (
        .UCLK(clk), .reset(reset), .baud_tick(baud_tick),
        .tx_data(data_c), .tx_valid(valid_c), .tx_ready(rdy_c),
        .tx_serial(ser_c), .tx_busy(bsy_c), .tx_done(dne_c)
    );

    typedef struct {
        int          sel;
        logic [7:0]  data;
        int          period;
        logic [11:0] frame;
        int          nbits;
        bit          hold;
        logic [7:0]  next;
        bit          inject;
        bit          chain;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input int s, input logic [7:0] d,
                                input int p, input logic [11:0] f,
                                input int n, input bit h,
                                input logic [7:0] nx, input bit inj,
                                input bit ch);
        vec_t v;
        v.sel = s; v.data = d; v.period = p; v.frame = f; v.nbits = n;
        v.hold = h; v.next = nx; v.inject = inj; v.chain = ch;
        return v;
    endfunction

    function automatic logic ser(input int s);
        case (s)
            0:       return ser_a;
            1:       return ser_b;
            default: return ser_c;
        endcase
    endfunction

    function automatic logic rdy(input int s);
        case (s)
            0:       return rdy_a;
            1:       return rdy_b;
            default: return rdy_c;
        endcase
    endfunction

    function automatic logic bsy(input int s);
        case (s)
            0:       return bsy_a;
            1:       return bsy_b;
            default: return bsy_c;
        endcase
    endfunction

    function automatic logic dne(input int s);
        case (s)
            0:       return dne_a;
            1:       return dne_b;
            default: return dne_c;
        endcase
    endfunction

    task automatic drive(input int s, input logic v, input logic [7:0] d);
        case (s)
            0:       begin valid_a = v; data_a = d; end
            1:       begin valid_b = v; data_b = d; end
            default: begin valid_c = v; data_c = d; end
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the tx_done cycle
    // (chain=1) or after the post-frame idle window.
    task automatic run_frame(input int id, input vec_t v);
        int bitlen;
        int total;
        int bad;
        int hs_bad;
        int done_bad;
        int idle_bad;
        bitlen   = 16 * v.period;
        total    = v.nbits * bitlen;
        bad      = 0;
        hs_bad   = 0;
        done_bad = 0;
        idle_bad = 0;
        drive(v.sel, 1'b1, v.data);
        baud_tick = 1'b1;
        chk($sformatf("v%0d ready_before", id), 32'(rdy(v.sel)), 32'd1);
        @(negedge clk);
        drive(v.sel, v.hold, v.hold ? v.next : ~v.data);
        for (int c = 0; c < total; c++) begin
            baud_tick = ((c % v.period) == v.period - 1);
            if (ser(v.sel) !== v.frame[c / bitlen]) bad++;
            if (rdy(v.sel) !== 1'b0 || bsy(v.sel) !== 1'b1) hs_bad++;
            if (dne(v.sel) !== 1'b0) done_bad++;
            if (v.inject && c == 3 * bitlen + 2) drive(v.sel, 1'b1, 8'h55);
            if (v.inject && c == 3 * bitlen + 3) drive(v.sel, 1'b0, ~v.data);
            if (c % bitlen == bitlen - 1) begin
                chk($sformatf("v%0d bit%0d bad_cycles", id, c / bitlen),
                    32'(bad), 32'd0);
                bad = 0;
            end
            @(negedge clk);
        end
        chk($sformatf("v%0d ready_busy_in_frame", id), 32'(hs_bad), 32'd0);
        chk($sformatf("v%0d early_done", id), 32'(done_bad), 32'd0);
        chk($sformatf("v%0d done_pulse", id), 32'(dne(v.sel)), 32'd1);
        chk($sformatf("v%0d ready_at_done", id), 32'(rdy(v.sel)), 32'd1);
        chk($sformatf("v%0d line_at_done", id), 32'(ser(v.sel)), 32'd1);
        if (!v.chain) begin
            drive(v.sel, 1'b0, v.data);
            baud_tick = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d done_one_cycle", id), 32'(dne(v.sel)), 32'd0);
            for (int i = 0; i < 24; i++) begin
                if (ser(v.sel) !== 1'b1 || bsy(v.sel) !== 1'b0 ||
                    rdy(v.sel) !== 1'b1 || dne(v.sel) !== 1'b0) idle_bad++;
                @(negedge clk);
            end
            chk($sformatf("v%0d idle_after", id), 32'(idle_bad), 32'd0);
        end
    endtask

    initial begin
        int dbad;
        vec_t rv;

        // Frames are {stop(s), parity, data, start}, sent LSB first
        vecs[0] = mk(0, 8'hA5, 1, 12'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 0, 8'h00, 0, 0);
        vecs[1] = mk(1, 8'h00, 1, {2'b11, 1'b1, 8'h00, 1'b0}, 12, 0, 8'h00, 0, 0);
        vecs[2] = mk(2, 8'hFF, 1, 12'({1'b1, 8'hFF, 1'b0}), 10, 0, 8'h00, 0, 0);
        vecs[3] = mk(0, 8'h71, 4, 12'({1'b1, 1'b0, 8'h71, 1'b0}), 11, 0, 8'h00, 0, 0);
        vecs[4] = mk(1, 8'h96, 4, {2'b11, 1'b1, 8'h96, 1'b0}, 12, 0, 8'h00, 0, 0);
        vecs[5] = mk(0, 8'h07, 1, 12'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 0, 8'h00, 1, 0);
        vecs[6] = mk(0, 8'h3C, 1, 12'({1'b1, 1'b0, 8'h3C, 1'b0}), 11, 1, 8'hC3, 0, 1);
        vecs[7] = mk(0, 8'hC3, 1, 12'({1'b1, 1'b0, 8'hC3, 1'b0}), 11, 0, 8'h00, 0, 0);

        #1 reset = 1'b0;
        #1;
        chk("rst serial", 32'(ser_a), 32'd1);
        chk("rst ready", 32'(rdy_a), 32'd1);
        chk("rst busy", 32'(bsy_a), 32'd0);
        chk("rst done", 32'(dne_a), 32'd0);
        chk("rst b/c lines", 32'({ser_b, ser_c, rdy_b, rdy_c}), 32'hF);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        baud_tick = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle tick no effect", 32'({ser_a, rdy_a, bsy_a}), 32'b110);

        for (int i = 0; i < 8; i++) run_frame(i, vecs[i]);

        // Abort during data bit 3 of 0xF0 (bit 3 is 0 on the line)
        drive(0, 1'b1, 8'hF0);
        baud_tick = 1'b1;
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        repeat (4 * 16 + 5) @(negedge clk);
        chk("pre-abort data bit3", 32'({ser_a, bsy_a}), 32'b01);
        #2 reset = 1'b0;
        #1;
        chk("abort serial", 32'(ser_a), 32'd1);
        chk("abort ready", 32'(rdy_a), 32'd1);
        chk("abort busy", 32'(bsy_a), 32'd0);
        dbad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (dne_a !== 1'b0 || ser_a !== 1'b1) dbad++;
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dne_a !== 1'b0 || ser_a !== 1'b1 || bsy_a !== 1'b0) dbad++;
        end
        chk("abort no done", 32'(dbad), 32'd0);

        rv = mk(0, 8'h81, 1, 12'({1'b1, 1'b0, 8'h81, 1'b0}), 11, 0, 8'h00, 0, 0);
        run_frame(8, rv);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
